// File: rtl/dds_sweep_controller.sv
// Frequency-sweep scheduler for the DDS: steps the phase-accumulator tuning word
// from a start word toward a stop word, holding each word for a programmed dwell.
module dds_sweep_controller #(
  parameter int PHASE_W = 10,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_start,
  input  logic [PHASE_W-1:0] cfg_stop,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_repeat,
  input  logic               start,
  input  logic               abort,
  output logic [PHASE_W-1:0] tuning_word,
  output logic               acc_enable,
  output logic               busy,
  output logic               sweep_done,
  output logic               cfg_error
);

  typedef enum logic [0:0] {IDLE, DWELL} state_t;

  state_t state, state_nxt;

  logic [PHASE_W-1:0] start_reg, start_reg_nxt;
  logic [PHASE_W-1:0] stop_reg,  stop_reg_nxt;
  logic [PHASE_W-1:0] step_reg,  step_reg_nxt;
  logic [DWELL_W-1:0] dwell_reg, dwell_reg_nxt;
  logic               repeat_reg, repeat_reg_nxt;
  logic               configured, configured_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [PHASE_W-1:0] tuning_word_nxt;
  logic               acc_enable_nxt, busy_nxt, sweep_done_nxt, cfg_error_nxt;

  // The extra MSB catches accumulator wrap so a sweep can never fold back to a low word.
  logic [PHASE_W:0]   next_word;
  logic               next_fits;

  assign next_word = {1'b0, tuning_word} + {1'b0, step_reg};
  assign next_fits = !next_word[PHASE_W] && (next_word[PHASE_W-1:0] <= stop_reg);

  assign cfg_ready = (state == IDLE);

  // NOTE: registers only take non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the simulator evaluates blocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      start_reg   <= '0;
      stop_reg    <= '0;
      step_reg    <= '0;
      dwell_reg   <= '0;
      repeat_reg  <= 1'b0;
      configured  <= 1'b0;
      dwell_cnt   <= '0;
      tuning_word <= '0;
      acc_enable  <= 1'b0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_reg   <= start_reg_nxt;
      stop_reg    <= stop_reg_nxt;
      step_reg    <= step_reg_nxt;
      dwell_reg   <= dwell_reg_nxt;
      repeat_reg  <= repeat_reg_nxt;
      configured  <= configured_nxt;
      dwell_cnt   <= dwell_cnt_nxt;
      tuning_word <= tuning_word_nxt;
      acc_enable  <= acc_enable_nxt;
      busy        <= busy_nxt;
      sweep_done  <= sweep_done_nxt;
      cfg_error   <= cfg_error_nxt;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold/default value first, so no path through the
    // case below leaves a signal unassigned and no latch is inferred.
    state_nxt       = state;
    start_reg_nxt   = start_reg;
    stop_reg_nxt    = stop_reg;
    step_reg_nxt    = step_reg;
    dwell_reg_nxt   = dwell_reg;
    repeat_reg_nxt  = repeat_reg;
    configured_nxt  = configured;
    dwell_cnt_nxt   = dwell_cnt;
    tuning_word_nxt = tuning_word;
    acc_enable_nxt  = acc_enable;
    busy_nxt        = busy;
    sweep_done_nxt  = 1'b0;
    cfg_error_nxt   = cfg_error;

    case (state)
      IDLE: begin
        acc_enable_nxt = 1'b0;
        busy_nxt       = 1'b0;
        if (cfg_valid) begin
          // A configuration transfer wins over a simultaneous start.
          start_reg_nxt  = cfg_start;
          stop_reg_nxt   = cfg_stop;
          step_reg_nxt   = cfg_step;
          dwell_reg_nxt  = cfg_dwell;
          repeat_reg_nxt = cfg_repeat;
          if (cfg_step == '0 || cfg_start > cfg_stop) begin
            cfg_error_nxt  = 1'b1;
            configured_nxt = 1'b0;
          end else begin
            cfg_error_nxt  = 1'b0;
            configured_nxt = 1'b1;
          end
        end else if (start && configured) begin
          state_nxt       = DWELL;
          tuning_word_nxt = start_reg;
          dwell_cnt_nxt   = dwell_reg;
          acc_enable_nxt  = 1'b1;
          busy_nxt        = 1'b1;
        end
      end

      DWELL: begin
        if (abort) begin
          state_nxt      = IDLE;
          acc_enable_nxt = 1'b0;
          busy_nxt       = 1'b0;
        end else if (dwell_cnt != '0) begin
          dwell_cnt_nxt = dwell_cnt - 1'b1;
        end else if (next_fits) begin
          tuning_word_nxt = next_word[PHASE_W-1:0];
          dwell_cnt_nxt   = dwell_reg;
        end else begin
          sweep_done_nxt = 1'b1;
          if (repeat_reg) begin
            tuning_word_nxt = start_reg;
            dwell_cnt_nxt   = dwell_reg;
          end else begin
            state_nxt      = IDLE;
            acc_enable_nxt = 1'b0;
            busy_nxt       = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Self-checking bench for dds_sweep_controller: directed scenarios plus random
// sweeps, compared cycle by cycle against an arithmetic model of the sweep.
module tb_dds_sweep_controller;

  localparam int PHASE_W = 10;
  localparam int DWELL_W = 16;

  logic               clock = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [PHASE_W-1:0] cfg_start;
  logic [PHASE_W-1:0] cfg_stop;
  logic [PHASE_W-1:0] cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_repeat;
  logic               start;
  logic               abort;
  logic [PHASE_W-1:0] tuning_word;
  logic               acc_enable;
  logic               busy;
  logic               sweep_done;
  logic               cfg_error;

  dds_sweep_controller #(.PHASE_W(PHASE_W), .DWELL_W(DWELL_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_start   (cfg_start),
    .cfg_stop    (cfg_stop),
    .cfg_step    (cfg_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_repeat  (cfg_repeat),
    .start       (start),
    .abort       (abort),
    .tuning_word (tuning_word),
    .acc_enable  (acc_enable),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .cfg_error   (cfg_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the accepted sweep configuration.
  int unsigned m_start, m_stop, m_step, m_dwell;
  bit          m_rep;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
  endtask

  function automatic int unsigned sweep_len();
    return ((m_stop - m_start) / m_step + 1) * (m_dwell + 1);
  endfunction

  // Expected outputs c cycles after the start edge (c=0 is the first cycle).
  function automatic void model(input int unsigned c, output int unsigned w,
                                output bit acc, output bit done);
    int unsigned hold = m_dwell + 1;
    int unsigned n    = (m_stop - m_start) / m_step + 1;
    int unsigned len  = n * hold;
    if (!m_rep) begin
      acc  = (c < len);
      done = (c == len);
      w    = (c < len) ? m_start + (c / hold) * m_step : m_start + (n - 1) * m_step;
    end else begin
      w    = m_start + ((c % len) / hold) * m_step;
      acc  = 1'b1;
      done = (c >= len) && (c % len == 0);
    end
  endfunction

  task automatic configure(input int unsigned s, input int unsigned e, input int unsigned st,
                           input int unsigned d, input bit r);
    cfg_start  = PHASE_W'(s);
    cfg_stop   = PHASE_W'(e);
    cfg_step   = PHASE_W'(st);
    cfg_dwell  = DWELL_W'(d);
    cfg_repeat = r;
    cfg_valid  = 1'b1;
    @(negedge clock);
    cfg_valid  = 1'b0;
    if (st != 0 && s <= e) begin
      m_start = s; m_stop = e; m_step = st; m_dwell = d; m_rep = r;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Compare ncyc cycles against the model; optionally hammer start/cfg_valid
  // with junk while the DUT should be busy.
  task automatic run_check(input int unsigned ncyc, input bit noise);
    int unsigned w;
    bit acc, done;
    int unsigned len = sweep_len();
    for (int unsigned c = 0; c < ncyc; c++) begin
      model(c, w, acc, done);
      check("tuning_word", 32'(tuning_word), w);
      check("acc_enable",  32'(acc_enable),  32'(acc));
      check("busy",        32'(busy),        32'(acc));
      check("sweep_done",  32'(sweep_done),  32'(done));
      check("cfg_ready",   32'(cfg_ready),   32'(!acc));
      if (noise && c < len) begin
        start      = 1'b1;
        cfg_valid  = 1'b1;
        cfg_start  = PHASE_W'($urandom);
        cfg_stop   = PHASE_W'($urandom);
        cfg_step   = PHASE_W'($urandom);
        cfg_dwell  = DWELL_W'($urandom_range(0, 7));
        cfg_repeat = 1'($urandom);
      end else begin
        start     = 1'b0;
        cfg_valid = 1'b0;
      end
      @(negedge clock);
    end
    start     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int unsigned w;
    bit acc, done;
    int unsigned s, e, st, d;
    bit r;

    reset = 1'b0; cfg_valid = 0; cfg_start = 0; cfg_stop = 0; cfg_step = 0;
    cfg_dwell = 0; cfg_repeat = 0; start = 0; abort = 0;

    // Reset values
    #12;
    check("rst_tuning_word", 32'(tuning_word), 0);
    check("rst_acc_enable",  32'(acc_enable),  0);
    check("rst_busy",        32'(busy),        0);
    check("rst_sweep_done",  32'(sweep_done),  0);
    check("rst_cfg_error",   32'(cfg_error),   0);
    check("rst_cfg_ready",   32'(cfg_ready),   1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Single sweep 10..20 step 5, dwell 2
    configure(10, 20, 5, 2, 0);
    check("single_cfg_error", 32'(cfg_error), 0);
    pulse_start();
    run_check(12, 1'b0);

    // Overflow boundary: carry at 1040 ends the sweep
    configure(1000, 1023, 20, 0, 0);
    pulse_start();
    run_check(5, 1'b0);

    // Repeat mode then abort
    configure(0, 3, 1, 0, 1);
    pulse_start();
    run_check(13, 1'b0);
    model(13, w, acc, done);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_acc_enable", 32'(acc_enable),  0);
    check("abort_busy",       32'(busy),        0);
    check("abort_sweep_done", 32'(sweep_done),  0);
    check("abort_tuning_word",32'(tuning_word), w);
    check("abort_cfg_ready",  32'(cfg_ready),   1);
    @(negedge clock);
    check("abort_no_done",    32'(sweep_done),  0);
    // Configuration survives an abort
    pulse_start();
    run_check(6, 1'b0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);

    // Bad configurations
    configure(50, 40, 5, 0, 0);
    check("bad_order_cfg_error", 32'(cfg_error), 1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check("bad_order_busy", 32'(busy), 0);
      check("bad_order_acc",  32'(acc_enable), 0);
      @(negedge clock);
    end
    configure(0, 10, 0, 0, 0);
    check("zero_step_cfg_error", 32'(cfg_error), 1);
    pulse_start();
    check("zero_step_busy", 32'(busy), 0);
    configure(100, 200, 30, 1, 0);
    check("good_cfg_clears_error", 32'(cfg_error), 0);

    // cfg_valid and start together: config latched, no sweep
    cfg_start = 5; cfg_stop = 9; cfg_step = 2; cfg_dwell = 0; cfg_repeat = 0;
    cfg_valid = 1'b1; start = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0; start = 1'b0;
    m_start = 5; m_stop = 9; m_step = 2; m_dwell = 0; m_rep = 0;
    check("collide_busy", 32'(busy), 0);
    check("collide_acc",  32'(acc_enable), 0);
    @(negedge clock);
    check("collide_still_idle", 32'(busy), 0);
    // Start and cfg_valid while busy change nothing
    pulse_start();
    run_check(6, 1'b1);
    pulse_start();
    run_check(5, 1'b0);

    // Asynchronous reset during the dwell of word 15
    configure(10, 20, 5, 2, 0);
    pulse_start();
    run_check(4, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("arst_tuning_word", 32'(tuning_word), 0);
    check("arst_acc_enable",  32'(acc_enable),  0);
    check("arst_busy",        32'(busy),        0);
    check("arst_sweep_done",  32'(sweep_done),  0);
    check("arst_cfg_ready",   32'(cfg_ready),   1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_done", 32'(sweep_done), 0);
      check("post_rst_word", 32'(tuning_word), 0);
      @(negedge clock);
    end

    // Random sweeps against the model
    for (int k = 0; k < 24; k++) begin
      s  = $urandom_range(0, 1000);
      e  = $urandom_range(s, 1023);
      st = $urandom_range(8, 300);
      d  = $urandom_range(0, 3);
      r  = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        if (s > 0 && $urandom_range(0, 1) == 1) e = $urandom_range(0, s - 1);
        else st = 0;
        configure(s, e, st, d, r);
        check("rand_bad_cfg_error", 32'(cfg_error), 1);
        pulse_start();
        check("rand_bad_busy", 32'(busy), 0);
      end else begin
        configure(s, e, st, d, r);
        check("rand_cfg_error", 32'(cfg_error), 0);
        pulse_start();
        if (!r) begin
          run_check(sweep_len() + 2, 1'($urandom));
        end else begin
          run_check(2 * sweep_len() + 2, 1'b0);
          abort = 1'b1;
          @(negedge clock);
          abort = 1'b0;
          check("rand_abort_acc",  32'(acc_enable), 0);
          check("rand_abort_done", 32'(sweep_done), 0);
          @(negedge clock);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_controller.md
# dds_sweep_controller

Frequency-sweep scheduler for the direct digital synthesizer. It sits in front of the phase accumulator and supplies its phase-increment (tuning word) and enable. Software or a host loads a sweep configuration: start word, stop word, step and dwell. The block then steps the tuning word from start toward stop, holding each value for a programmed number of clocks, either once or repeatedly, and signals the end of each sweep.

## Interface
Parameters:
- PHASE_W, 10, width of tuning word; equal to the phase accumulator width
- DWELL_W, 16, width of dwell counter

Ports:
- clock  input  1  system clock (1 MHz nominal)
- reset  input  1  asynchronous, active-low reset
- cfg_valid  input  1  configuration offered
- cfg_ready  output  1  configuration can be accepted; high only in IDLE
- cfg_start  input  PHASE_W  first tuning word
- cfg_stop  input  PHASE_W  last allowed tuning word (inclusive)
- cfg_step  input  PHASE_W  increment between words
- cfg_dwell  input  DWELL_W  extra hold cycles per word; each word lasts cfg_dwell+1 clocks
- cfg_repeat  input  1  1 = restart sweep from start word after stop; 0 = single sweep
- start  input  1  begin sweep (sampled level, acts as a pulse in IDLE)
- abort  input  1  terminate sweep immediately
- tuning_word  output  PHASE_W  phase increment to accumulator
- acc_enable  output  1  accumulator advance enable
- busy  output  1  high in DWELL state
- sweep_done  output  1  one-cycle pulse at end of every completed sweep
- cfg_error  output  1  last offered configuration was rejected

## Operation
- Configuration transfers on a clock edge with cfg_valid && cfg_ready. All cfg_* fields are latched into internal registers.
- Validation at transfer:
  - If cfg_step==0 or cfg_start>cfg_stop, the configuration is rejected. cfg_error is set to 1 and the configured flag is cleared.
  - Otherwise cfg_error is set to 0 and the configured flag is set to 1.
- States: IDLE, DWELL.
- IDLE:
  - cfg_ready=1, acc_enable=0, busy=0. tuning_word holds its last value.
  - start with configured flag=1 moves to DWELL. On that edge: tuning_word<=start_reg, dwell_cnt<=dwell_reg, acc_enable<=1.
  - start with configured flag=0 is ignored.
  - cfg transfer and start in the same cycle: the configuration is latched and start is ignored.
- DWELL:
  - cfg_ready=0, busy=1, acc_enable=1.
  - dwell_cnt decrements each cycle while nonzero.
  - When dwell_cnt==0, compute next = tuning_word + step_reg in PHASE_W+1 bits.
  - If next <= stop_reg and there is no carry: tuning_word<=next, dwell_cnt<=dwell_reg.
  - Otherwise the sweep ends and sweep_done<=1 for one cycle:
    - If repeat_reg=1: tuning_word<=start_reg, dwell_cnt<=dwell_reg, stay in DWELL.
    - If repeat_reg=0: go to IDLE, acc_enable<=0, tuning_word holds the final word.
  - start is ignored in DWELL. cfg_valid is not accepted in DWELL.
- abort has priority over every other event. In DWELL it forces IDLE on the next edge with acc_enable<=0 and no sweep_done. In IDLE it has no effect. The configuration is retained after abort.
- Words emitted per sweep: N = floor((stop-start)/step)+1. Sweep length is N*(dwell+1) clocks.

## Timing
- Reset values (asynchronous, while reset=0): state IDLE, tuning_word=0, acc_enable=0, busy=0, sweep_done=0, cfg_error=0, configured flag=0, all config registers 0. cfg_ready=1 after reset.
- All outputs are registered except cfg_ready, which is decoded from the state register.
- Latency from start sampled at edge T: tuning_word=start and acc_enable=1 are valid after edge T.
- The word emitted at edge T changes at edge T+dwell+1.
- sweep_done is high during the first cycle after the final word's last dwell cycle. That cycle coincides with acc_enable falling (single mode) or tuning_word returning to start (repeat mode).
- Reset asserted mid-sweep returns all state to reset values immediately, with no sweep_done. The configuration must be reloaded.
- A new configuration offered on the same edge that the state returns to IDLE is not accepted, because cfg_ready was 0 in that cycle.

## Test plan
- Single sweep: cfg start=10, stop=20, step=5, dwell=2, repeat=0, then start. Required: tuning_word 10,15,20, each for exactly 3 clocks, acc_enable high for 9 clocks; then sweep_done pulses once, acc_enable=0, tuning_word stays 20, cfg_ready=1.
- Overflow boundary: start=1000, stop=1023, step=20, dwell=0. Required: words 1000 then 1020, each 1 clock; the carry at 1040 ends the sweep and sweep_done pulses; tuning_word never wraps to 16.
- Repeat mode: start=0, stop=3, step=1, dwell=0, repeat=1. Required: 0,1,2,3,0,1,… with sweep_done pulsing every 4 clocks when 0 reappears; abort then gives acc_enable=0 next clock with no sweep_done.
- Bad config: cfg start=50, stop=40, then start; separately step=0. Required: cfg_error=1, start ignored, busy stays 0. A subsequent valid config clears cfg_error.
- Collisions: cfg_valid and start in the same cycle means no sweep begins; start while busy changes nothing; cfg_valid while busy is not accepted (cfg_ready=0).
- Reset mid-sweep: assert reset=0 asynchronously during the dwell of word 15 of the first scenario. Required: outputs go to 0 immediately; after release, start without reconfiguration is ignored.
